mining_job_scheduler: RTL and testbench

- Sequences one mining job across the header padder and the double-SHA-256 core.
- Per nonce: latches the job header and drives the padder inputs, waits for the padder's registered output, then pulses the hash core and waits for its result.
- Compares each hash against the job target; stops on the first hit, on range exhaustion, on abort, or on core timeout.
- Sits between the host job interface and the padder/hash datapath.

---
 rtl/mining_pkg.sv | 39 +++
 rtl/nonce_range_iter.sv | 48 ++++
 rtl/mining_job_scheduler.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mining_job_scheduler.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
// ----------------------------------------------------------------------------
// mining_pkg
// Shared definitions for the mining job scheduler slice:
//   - scheduler state encoding
//   - result status codes reported to the host
//   - block header field widths
// No ports; imported by mining_job_scheduler and nonce_range_iter.
// ----------------------------------------------------------------------------
package mining_pkg;

    localparam int VERSION_W = 32;
    localparam int HASH_W    = 256;
    localparam int TIME_W    = 32;
    localparam int BITS_W    = 32;
    localparam int NONCE_W   = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PAD_WAIT  = 3'd1,
        START     = 3'd2,
        WAIT_HASH = 3'd3,
        CHECK     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_FOUND     = 2'd0,
        RES_EXHAUSTED = 2'd1,
        RES_ABORTED   = 2'd2,
        RES_TIMEOUT   = 2'd3
    } result_t;

    // Difficulty test: a digest wins only when strictly below the target,
    // both taken as 256-bit unsigned integers.
    function automatic logic hash_below_target(input logic [HASH_W-1:0] hash,
                                               input logic [HASH_W-1:0] target);
        return hash < target;
    endfunction

endpackage

// File: rtl/nonce_range_iter.sv
// ----------------------------------------------------------------------------
// nonce_range_iter
// Holds the current nonce and the inclusive end of the job's nonce range.
// The range wraps modulo 2^32, so the last-nonce flag is a plain equality
// test against the stored end value rather than a magnitude compare.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   load         in   capture start_value as the current nonce and end_value
//   start_value  in   first nonce of the range (inclusive)
//   end_value    in   last nonce of the range (inclusive)
//   advance      in   step to the next nonce (wraps 0xFFFFFFFF -> 0)
//   nonce        out  current nonce
//   is_last      out  current nonce equals the range end
// ----------------------------------------------------------------------------
module nonce_range_iter
    import mining_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [NONCE_W-1:0] start_value,
    input  logic [NONCE_W-1:0] end_value,
    input  logic               advance,
    output logic [NONCE_W-1:0] nonce,
    output logic               is_last
);

    logic [NONCE_W-1:0] nonce_reg;
    logic [NONCE_W-1:0] end_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nonce_reg <= '0;
            end_reg   <= '0;
        end else if (load) begin
            nonce_reg <= start_value;
            end_reg   <= end_value;
        end else if (advance) begin
            nonce_reg <= nonce_reg + NONCE_W'(1);
        end
    end

    assign nonce   = nonce_reg;
    assign is_last = (nonce_reg == end_reg);

endmodule

// File: rtl/mining_job_scheduler.sv
// ----------------------------------------------------------------------------
// mining_job_scheduler
// Runs one mining job: for each nonce in the inclusive (wrapping) range it
// presents the header to the padder, waits for the padder register, pulses
// the double-SHA-256 core, waits for the digest and compares it against the
// job target. The job ends on the first hit, range exhaustion, abort or a
// hash-core timeout, and a single result pulse is issued.
//
// Ports:
//   clk, reset                      clock / asynchronous active-high reset
//   job_valid, job_ready            host job handshake (ready only when idle
//                                   and not presenting a result)
//   job_version .. job_target       job header fields and target
//   nonce_start, nonce_end          inclusive nonce range (may wrap)
//   abort                           cancel the running job
//   hdr_version .. hdr_nonce        latched header fields to the padder
//   hash_start                      one-cycle pulse to the hash core
//   hash_done, hash_value           digest return from the hash core
//   result_valid                    one-cycle pulse at job end
//   result_status/nonce/hash        job outcome, held until next accept
//   busy                            scheduler not idle
// ----------------------------------------------------------------------------
module mining_job_scheduler
    import mining_pkg::*;
#(
    parameter int PAD_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMO_W          = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [VERSION_W-1:0] job_version,
    input  logic [HASH_W-1:0]    job_prev_hash,
    input  logic [HASH_W-1:0]    job_merkle,
    input  logic [TIME_W-1:0]    job_timestamp,
    input  logic [BITS_W-1:0]    job_bits,
    input  logic [HASH_W-1:0]    job_target,
    input  logic [NONCE_W-1:0]   nonce_start,
    input  logic [NONCE_W-1:0]   nonce_end,
    input  logic                 abort,
    output logic [VERSION_W-1:0] hdr_version,
    output logic [HASH_W-1:0]    hdr_prev_hash,
    output logic [HASH_W-1:0]    hdr_merkle_root,
    output logic [TIME_W-1:0]    hdr_timestamp,
    output logic [BITS_W-1:0]    hdr_bits,
    output logic [NONCE_W-1:0]   hdr_nonce,
    output logic                 hash_start,
    input  logic                 hash_done,
    input  logic [HASH_W-1:0]    hash_value,
    output logic                 result_valid,
    output logic [1:0]           result_status,
    output logic [NONCE_W-1:0]   result_nonce,
    output logic [HASH_W-1:0]    result_hash,
    output logic                 busy
);

    localparam int PAD_W = (PAD_LATENCY > 0) ? $clog2(PAD_LATENCY + 1) : 1;

    state_t               state_reg;
    state_t               state_next;

    logic [PAD_W-1:0]     pad_cnt_reg;
    logic [TMO_W-1:0]     tmo_reg;
    logic [TMO_W-1:0]     tmo_inc;
    logic                 tmo_expire;

    logic [VERSION_W-1:0] version_reg;
    logic [HASH_W-1:0]    prev_hash_reg;
    logic [HASH_W-1:0]    merkle_reg;
    logic [TIME_W-1:0]    timestamp_reg;
    logic [BITS_W-1:0]    bits_reg;
    logic [HASH_W-1:0]    target_reg;
    logic [HASH_W-1:0]    hash_reg;

    logic                 result_valid_reg;
    result_t              result_status_reg;
    logic [NONCE_W-1:0]   result_nonce_reg;
    logic [HASH_W-1:0]    result_hash_reg;

    logic                 job_accept;
    logic                 hash_hit;
    logic                 nonce_last;
    logic                 nonce_advance;
    logic                 finish;
    result_t              finish_status;

    assign job_accept = job_valid && job_ready;
    assign hash_hit   = hash_below_target(hash_reg, target_reg);

    // START clears the counter, so in the k-th WAIT_HASH cycle it holds k-1.
    // The timeout fires when the counter steps to TIMEOUT_CYCLES-1, which puts
    // the TIMEOUT result pulse exactly TIMEOUT_CYCLES cycles after hash_start.
    assign tmo_inc    = tmo_reg + TMO_W'(1);
    assign tmo_expire = (tmo_inc == TMO_W'(TIMEOUT_CYCLES - 1));

    // Nonce steps only when CHECK decides to try another one.
    assign nonce_advance = (state_reg == CHECK) && (state_next == PAD_WAIT);

    nonce_range_iter u_nonce_iter (
        .clk         (clk),
        .reset       (reset),
        .load        (job_accept),
        .start_value (nonce_start),
        .end_value   (nonce_end),
        .advance     (nonce_advance),
        .nonce       (hdr_nonce),
        .is_last     (nonce_last)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and job-termination decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        finish        = 1'b0;
        finish_status = RES_FOUND;
        case (state_reg)
            IDLE: begin
                if (job_accept) begin
                    state_next = PAD_WAIT;
                end
            end
            PAD_WAIT: begin
                // Counter is about to hit zero: padder output is valid next cycle.
                if (pad_cnt_reg <= PAD_W'(1)) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_HASH;
            end
            WAIT_HASH: begin
                // A digest arriving on the last allowed cycle still counts.
                if (hash_done) begin
                    state_next = CHECK;
                end else if (tmo_expire) begin
                    state_next    = IDLE;
                    finish        = 1'b1;
                    finish_status = RES_TIMEOUT;
                end
            end
            CHECK: begin
                if (hash_hit) begin
                    state_next    = IDLE;
                    finish        = 1'b1;
                    finish_status = RES_FOUND;
                end else if (nonce_last) begin
                    state_next    = IDLE;
                    finish        = 1'b1;
                    finish_status = RES_EXHAUSTED;
                end else begin
                    state_next = PAD_WAIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides every other event once a job is running.
        if (abort && (state_reg != IDLE)) begin
            state_next    = IDLE;
            finish        = 1'b1;
            finish_status = RES_ABORTED;
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        hash_start = (state_reg == START);
        busy       = (state_reg != IDLE);
        // The result cycle is spent in IDLE; holding ready low there keeps a
        // waiting job from being taken in the same cycle as the result.
        job_ready  = (state_reg == IDLE) && !result_valid_reg;
    end

    // ------------------------------------------------------------------
    // Job header, pad / timeout counters, digest capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            version_reg   <= '0;
            prev_hash_reg <= '0;
            merkle_reg    <= '0;
            timestamp_reg <= '0;
            bits_reg      <= '0;
            target_reg    <= '0;
            pad_cnt_reg   <= '0;
            tmo_reg       <= '0;
            hash_reg      <= '0;
        end else begin
            if (job_accept) begin
                version_reg   <= job_version;
                prev_hash_reg <= job_prev_hash;
                merkle_reg    <= job_merkle;
                timestamp_reg <= job_timestamp;
                bits_reg      <= job_bits;
                target_reg    <= job_target;
            end

            if ((state_next == PAD_WAIT) && (state_reg != PAD_WAIT)) begin
                pad_cnt_reg <= PAD_W'(PAD_LATENCY);
            end else if ((state_reg == PAD_WAIT) && (pad_cnt_reg != '0)) begin
                pad_cnt_reg <= pad_cnt_reg - PAD_W'(1);
            end

            if (state_reg == START) begin
                tmo_reg <= '0;
            end else if (state_reg == WAIT_HASH) begin
                tmo_reg <= tmo_inc;
            end

            if ((state_reg == WAIT_HASH) && hash_done) begin
                hash_reg <= hash_value;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers: cleared on accept, loaded on job end
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid_reg  <= 1'b0;
            result_status_reg <= RES_FOUND;
            result_nonce_reg  <= '0;
            result_hash_reg   <= '0;
        end else begin
            result_valid_reg <= finish;
            if (job_accept) begin
                result_status_reg <= RES_FOUND;
                result_nonce_reg  <= '0;
                result_hash_reg   <= '0;
            end else if (finish) begin
                result_status_reg <= finish_status;
                result_nonce_reg  <= hdr_nonce;
                result_hash_reg   <= (finish_status == RES_FOUND) ? hash_reg : '0;
            end
        end
    end

    assign hdr_version     = version_reg;
    assign hdr_prev_hash   = prev_hash_reg;
    assign hdr_merkle_root = merkle_reg;
    assign hdr_timestamp   = timestamp_reg;
    assign hdr_bits        = bits_reg;

    assign result_valid  = result_valid_reg;
    assign result_status = result_status_reg;
    assign result_nonce  = result_nonce_reg;
    assign result_hash   = result_hash_reg;

endmodule

// File: tb/tb_mining_job_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mining_job_scheduler
// Scoreboard bench: each issued job pushes its expected nonce sequence and
// outcome (computed by walking the range in plain arithmetic); a monitor pops
// and compares on hash_start and result_valid. A behavioural hash core
// responds with a per-job winning digest or a guaranteed-losing one.
// ----------------------------------------------------------------------------
module tb_mining_job_scheduler;
    import mining_pkg::*;

    localparam int T = 64;   // timeout used for this bench

    // mode codes for the issued job / responder behaviour
    localparam int M_NORMAL    = 0;
    localparam int M_SILENT    = 1;
    localparam int M_ABORTDONE = 2;
    localparam int M_ABORTPAD  = 3;
    localparam int M_ABORTTMO  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         job_valid, job_ready;
    logic [31:0]  job_version, job_timestamp, job_bits, nonce_start, nonce_end;
    logic [255:0] job_prev_hash, job_merkle, job_target;
    logic         abort, drv_abort, resp_abort;
    logic [31:0]  hdr_version, hdr_timestamp, hdr_bits, hdr_nonce;
    logic [255:0] hdr_prev_hash, hdr_merkle_root;
    logic         hash_start, hash_done;
    logic [255:0] hash_value;
    logic         result_valid, busy;
    logic [1:0]   result_status;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;

    assign abort = drv_abort | resp_abort;

    mining_job_scheduler #(.PAD_LATENCY(1), .TIMEOUT_CYCLES(T), .TMO_W(7)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_version(job_version), .job_prev_hash(job_prev_hash),
        .job_merkle(job_merkle), .job_timestamp(job_timestamp),
        .job_bits(job_bits), .job_target(job_target),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .abort(abort),
        .hdr_version(hdr_version), .hdr_prev_hash(hdr_prev_hash),
        .hdr_merkle_root(hdr_merkle_root), .hdr_timestamp(hdr_timestamp),
        .hdr_bits(hdr_bits), .hdr_nonce(hdr_nonce),
        .hash_start(hash_start), .hash_done(hash_done), .hash_value(hash_value),
        .result_valid(result_valid), .result_status(result_status),
        .result_nonce(result_nonce), .result_hash(result_hash),
        .busy(busy)
    );

    typedef struct {
        logic [1:0]   status;
        logic [31:0]  nonce;
        logic [255:0] hash;
        int           starts;
        int           gap;      // cycles from last hash_start to result, -1 = don't care
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] nonce_q[$];

    int checks = 0;
    int failures = 0;
    int job_count = 0;

    // job / responder context shared by driver, responder and monitor
    int           resp_mode = M_NORMAL;
    logic         spurious_en = 1'b0;
    logic [31:0]  win_nonce_g;
    logic [255:0] win_hash_g;
    logic [31:0]  cur_version, cur_timestamp, cur_bits;
    logic [255:0] cur_prev, cur_merkle;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural hash core
    // ------------------------------------------------------------------
    initial begin
        logic [31:0]  n;
        logic [255:0] tmp;
        int           lat;
        hash_done  = 1'b0;
        hash_value = '0;
        resp_abort = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && hash_start && resp_mode != M_SILENT && resp_mode != M_ABORTTMO) begin
                n   = hdr_nonce;
                lat = $urandom_range(1, 4);
                repeat (lat) @(negedge clk);
                if (!reset) begin
                    tmp        = rand256();
                    hash_done  = 1'b1;
                    hash_value = (n == win_nonce_g) ? win_hash_g : {32'hFFFF_FFFF, tmp[223:0]};
                    resp_abort = (resp_mode == M_ABORTDONE);
                    @(negedge clk);
                    resp_abort = 1'b0;
                    // A stray winning digest while the scheduler is in CHECK.
                    if (spurious_en && $urandom_range(0, 1) == 1) begin
                        hash_value = '0;
                        @(negedge clk);
                    end
                    hash_done  = 1'b0;
                    hash_value = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        exp_t        x;
        logic [31:0] en;
        int          starts = 0;
        int          cyc = 0;
        int          last_start = 0;
        logic        chk_ready_next = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                starts = 0;
                chk_ready_next = 1'b0;
            end else begin
                if (chk_ready_next) begin
                    check("ready_after_result", job_ready, 1'b1);
                    chk_ready_next = 1'b0;
                end
                if (hash_start) begin
                    starts++;
                    last_start = cyc;
                    if (nonce_q.size() == 0) begin
                        check("unexpected_hash_start", 1'b1, 1'b0);
                    end else begin
                        en = nonce_q.pop_front();
                        check("hdr_nonce", hdr_nonce, en);
                        check("hdr_small_fields", {hdr_version, hdr_timestamp, hdr_bits},
                              {cur_version, cur_timestamp, cur_bits});
                        check("hdr_prev_hash", hdr_prev_hash, cur_prev);
                        check("hdr_merkle_root", hdr_merkle_root, cur_merkle);
                    end
                end
                if (result_valid) begin
                    check("ready_low_in_result", job_ready, 1'b0);
                    check("busy_low_in_result", busy, 1'b0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_result_valid", 1'b1, 1'b0);
                    end else begin
                        x = exp_q.pop_front();
                        job_count++;
                        $display("job %0d: status=%0d nonce=%h starts=%0d gap=%0d",
                                 job_count, result_status, result_nonce, starts, cyc - last_start);
                        check("result_status", result_status, x.status);
                        check("result_nonce", result_nonce, x.nonce);
                        check("result_hash", result_hash, x.hash);
                        check("hash_start_count", starts, x.starts);
                        if (x.gap >= 0) check("timeout_gap", cyc - last_start, x.gap);
                        check("nonces_all_tried", nonce_q.size(), 0);
                    end
                    starts = 0;
                    chk_ready_next = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic randomize_job_inputs();
        job_version   = $urandom;
        job_timestamp = $urandom;
        job_bits      = $urandom;
        job_prev_hash = rand256();
        job_merkle    = rand256();
    endtask

    task automatic issue_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt,
                             input logic [31:0] wn, input logic [255:0] wh, input int mode);
        exp_t        x;
        logic [31:0] n;
        int          b;
        resp_mode   = mode;
        win_nonce_g = wn;
        win_hash_g  = wh;
        x.status = RES_ABORTED;
        x.nonce  = s;
        x.hash   = '0;
        x.starts = 1;
        x.gap    = -1;
        case (mode)
            M_NORMAL: begin
                // Walk the inclusive wrapping range until a hit or the end.
                n = s;
                x.starts = 0;
                for (int k = 0; k < 100000; k++) begin
                    nonce_q.push_back(n);
                    x.starts++;
                    if (n == wn && wh < tgt) begin
                        x.status = RES_FOUND; x.nonce = n; x.hash = wh;
                        break;
                    end
                    if (n == e) begin
                        x.status = RES_EXHAUSTED; x.nonce = n;
                        break;
                    end
                    n = n + 32'd1;
                end
            end
            M_SILENT: begin
                nonce_q.push_back(s);
                x.status = RES_TIMEOUT;
                x.gap    = T;
            end
            M_ABORTDONE: nonce_q.push_back(s);
            M_ABORTPAD:  x.starts = 0;
            M_ABORTTMO: begin
                nonce_q.push_back(s);
                x.gap = T;
            end
            default: ;
        endcase
        exp_q.push_back(x);

        @(negedge clk);
        randomize_job_inputs();
        cur_version   = job_version;
        cur_timestamp = job_timestamp;
        cur_bits      = job_bits;
        cur_prev      = job_prev_hash;
        cur_merkle    = job_merkle;
        job_target    = tgt;
        nonce_start   = s;
        nonce_end     = e;
        job_valid     = 1'b1;
        b = 0;
        while (!job_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (b >= 100) check("accept_wait", job_ready, 1'b1);
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        randomize_job_inputs();   // header must stay latched, not follow inputs
        nonce_start = $urandom;
        nonce_end   = $urandom;
        job_target  = '0;

        if (mode == M_ABORTPAD) begin
            drv_abort = 1'b1;
            @(posedge clk);
            #1;
            drv_abort = 1'b0;
        end else if (mode == M_ABORTTMO) begin
            b = 0;
            @(negedge clk);
            while (!hash_start && b < 20) begin
                @(negedge clk);
                b++;
            end
            repeat (T - 1) @(negedge clk);
            drv_abort = 1'b1;      // lands in the cycle the timeout would fire
            @(negedge clk);
            drv_abort = 1'b0;
        end
    endtask

    task automatic wait_done();
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        check("job_completed", exp_q.size(), 0);
        if (exp_q.size() != 0) begin
            reset = 1'b1;
            exp_q.delete();
            nonce_q.delete();
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        logic [31:0]  s, e, wn, top;
        logic [255:0] tgt, wh, r;
        int           b, mode;

        job_valid = 1'b0;
        drv_abort = 1'b0;
        randomize_job_inputs();
        job_target  = '0;
        nonce_start = '0;
        nonce_end   = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_job_ready", job_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_hash_start", hash_start, 1'b0);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_result", {result_status, result_nonce}, '0);
        check("rst_result_hash", result_hash, '0);
        check("rst_hdr_nonce", hdr_nonce, '0);
        check("rst_hdr_fields", {hdr_version, hdr_timestamp, hdr_bits}, '0);
        check("rst_hdr_prev_hash", hdr_prev_hash, '0);
        @(negedge clk);
        reset = 1'b0;

        // Four losing nonces -> EXHAUSTED at 0x13
        issue_job(32'h10, 32'h13, {32'h7000_0000, 224'h0}, 32'h50, '0, M_NORMAL);
        wait_done();
        // Winner at 0x105 -> FOUND after 6 starts
        issue_job(32'h100, 32'h1FF, {32'h0000_FFFF, 224'h0}, 32'h105, '0, M_NORMAL);
        wait_done();
        // Wrapping range
        issue_job(32'hFFFF_FFFE, 32'h1, {32'h7000_0000, 224'h0}, 32'h1000, '0, M_NORMAL);
        wait_done();
        // Single nonce, digest equal to target is not a hit
        tgt = {32'h1234_5678, 224'h0} | 256'h99;
        issue_job(32'hABCD, 32'hABCD, tgt, 32'hABCD, tgt, M_NORMAL);
        wait_done();
        // Single nonce, digest one below target is a hit
        issue_job(32'hABCD, 32'hABCD, tgt, 32'hABCD, tgt - 256'd1, M_NORMAL);
        wait_done();
        // Hash core never answers -> TIMEOUT
        issue_job(32'h77, 32'h80, {32'h7000_0000, 224'h0}, 32'h77, '0, M_SILENT);
        wait_done();
        // Abort together with a winning hash_done
        issue_job(32'h300, 32'h310, {32'h7000_0000, 224'h0}, 32'h300, '0, M_ABORTDONE);
        wait_done();
        // Abort together with the timeout
        issue_job(32'h400, 32'h410, {32'h7000_0000, 224'h0}, 32'h400, '0, M_ABORTTMO);
        wait_done();
        // Abort during the padder wait, before any hash_start
        issue_job(32'h500, 32'h510, {32'h7000_0000, 224'h0}, 32'h500, '0, M_ABORTPAD);
        wait_done();

        // Abort while idle is ignored (monitor flags any result pulse)
        resp_mode = M_NORMAL;
        @(negedge clk);
        drv_abort = 1'b1;
        repeat (3) @(negedge clk);
        drv_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_abort_busy", busy, 1'b0);
        check("idle_abort_ready", job_ready, 1'b1);

        // Reset in the middle of WAIT_HASH
        issue_job(32'h20, 32'h30, {32'h7000_0000, 224'h0}, 32'h99, '0, M_SILENT);
        b = 0;
        while (!hash_start && b < 20) begin
            @(negedge clk);
            b++;
        end
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_job_ready", job_ready, 1'b1);
        check("midrst_busy_start", {busy, hash_start, result_valid}, 3'b000);
        check("midrst_hdr_nonce", hdr_nonce, '0);
        check("midrst_hdr_merkle", hdr_merkle_root, '0);
        check("midrst_result", {result_status, result_nonce}, '0);
        exp_q.delete();
        nonce_q.delete();
        resp_mode = M_NORMAL;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue_job(32'h40, 32'h45, {32'h7000_0000, 224'h0}, 32'h43, '0, M_NORMAL);
        wait_done();

        // Randomized jobs
        spurious_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            mode = ($urandom_range(0, 9) == 0) ? M_SILENT : M_NORMAL;
            s    = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFFF - $urandom_range(0, 4));
            e    = s + $urandom_range(0, 7);
            r    = rand256();
            top  = $urandom_range(1, 32'hFFFF_FFFE);
            tgt  = {top, r[223:0]};
            wn   = s + $urandom_range(0, 10);
            case ($urandom_range(0, 2))
                0:       wh = tgt;
                1:       wh = tgt - 256'd1;
                default: begin
                    r  = rand256();
                    wh = {32'($urandom_range(0, top - 1)), r[223:0]};
                end
            endcase
            issue_job(s, e, tgt, wn, wh, mode);
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
